// File: rtl/dsp_conv3x3_stream.sv
`default_nettype none
// ============================================================================
// Module      : dsp_conv3x3_stream
// Description : Streaming 3x3 convolution with programmable signed coefficients,
//               two line buffers and valid/ready flow control. Emits interior
//               ("valid") pixels only. Optional macro DSP_CONV_ABS_EN maps
//               negative results to their magnitude before clamping.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_conv3x3_stream #(
    parameter int PIX_W     = 8,
    parameter int COEF_W    = 8,
    parameter int MAX_WIDTH = 1024,
    parameter int DIM_W     = 11,
    parameter int ACC_W     = PIX_W + COEF_W + 4
) (
    input  logic                dsp_clk,
    input  logic                reset,
    input  logic [DIM_W-1:0]    cfg_width,
    input  logic [DIM_W-1:0]    cfg_height,
    input  logic [3:0]          cfg_shift,
    input  logic                coef_we,
    input  logic [3:0]          coef_addr,
    input  logic [COEF_W-1:0]   coef_data,
    input  logic [PIX_W-1:0]    din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic [PIX_W-1:0]    dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                frame_done,
    output logic                cfg_err
);

    localparam int ADDR_W = $clog2(MAX_WIDTH);
    localparam int PROD_W = PIX_W + COEF_W + 1;
    localparam logic [DIM_W-1:0]        c_max_width = DIM_W'(MAX_WIDTH);
    localparam logic signed [ACC_W-1:0] c_pix_max   = ACC_W'((1 << PIX_W) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic [PIX_W-1:0]         r_lb0 [MAX_WIDTH];
    logic [PIX_W-1:0]         r_lb1 [MAX_WIDTH];
    logic [PIX_W-1:0]         r_win [9];
    logic signed [COEF_W-1:0] r_coef_sh [9];
    logic signed [COEF_W-1:0] r_coef [9];
    logic                     r_win_vld, r_sum_vld, r_dout_vld;
    logic signed [ACC_W-1:0]  r_sum;
    logic [PIX_W-1:0]         r_dout;
    logic [DIM_W-1:0]         r_width, r_height, r_col, r_row;
    logic [3:0]               r_shift;

    logic                     w_adv, w_legal, w_acc, w_din_ready, w_cfg_err, w_frame_done;
    logic                     w_launch, w_pos_last, w_empty;
    logic [DIM_W-1:0]         w_col, w_row, w_width;
    logic [ADDR_W-1:0]        w_addr;
    logic signed [PROD_W-1:0] w_prod [9];
    logic signed [ACC_W-1:0]  w_mac, w_shifted, w_mag;
    logic [PIX_W-1:0]         w_clamp;

    assign w_adv   = !r_dout_vld || dout_ready;
    assign w_legal = (cfg_width >= DIM_W'(3)) && (cfg_width <= c_max_width) &&
                     (cfg_height >= DIM_W'(3));
    assign w_acc   = din_valid && w_din_ready;
    assign w_empty = !r_win_vld && !r_sum_vld && !r_dout_vld;

    // In IDLE the incoming pixel is always (0,0) of a frame using the live config.
    assign w_col      = (r_state == S_IDLE) ? '0 : r_col;
    assign w_row      = (r_state == S_IDLE) ? '0 : r_row;
    assign w_width    = (r_state == S_IDLE) ? cfg_width : r_width;
    assign w_addr     = w_col[ADDR_W-1:0];
    assign w_launch   = (w_row >= DIM_W'(2)) && (w_col >= DIM_W'(2));
    assign w_pos_last = (w_row == r_height - DIM_W'(1)) && (w_col == r_width - DIM_W'(1));

    always_ff @(posedge dsp_clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_din_ready  = 1'b0;
        w_cfg_err    = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cfg_err   = !w_legal;
                w_din_ready = w_legal;
                if (din_valid && w_legal) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_din_ready = w_adv;
                if (din_valid && w_adv && w_pos_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_empty) begin
                    w_frame_done = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (reset) begin
            w_din_ready  = 1'b0;
            w_cfg_err    = 1'b0;
            w_frame_done = 1'b0;
        end
    end

    // lb0 holds the previous row, lb1 the row before it, indexed by column.
    always_ff @(posedge dsp_clk) begin
        if (w_acc) begin
            r_lb1[w_addr] <= r_lb0[w_addr];
            r_lb0[w_addr] <= din;
        end
    end

    always_ff @(posedge dsp_clk) begin
        if (reset) begin
            r_col      <= '0;
            r_row      <= '0;
            r_width    <= '0;
            r_height   <= '0;
            r_shift    <= '0;
            r_win_vld  <= 1'b0;
            r_sum_vld  <= 1'b0;
            r_sum      <= '0;
            r_dout_vld <= 1'b0;
            r_dout     <= '0;
            for (int k = 0; k < 9; k++) begin
                r_coef_sh[k] <= '0;
                r_coef[k]    <= '0;
                r_win[k]     <= '0;
            end
        end else begin
            if (coef_we && (coef_addr < 4'd9)) r_coef_sh[coef_addr] <= coef_data;
            if (w_acc && (r_state == S_IDLE)) begin
                r_width  <= cfg_width;
                r_height <= cfg_height;
                r_shift  <= cfg_shift;
                for (int k = 0; k < 9; k++) r_coef[k] <= r_coef_sh[k];
            end
            if (w_acc) begin
                if (w_col == w_width - DIM_W'(1)) begin
                    r_col <= '0;
                    r_row <= w_row + DIM_W'(1);
                end else begin
                    r_col <= w_col + DIM_W'(1);
                    r_row <= w_row;
                end
                // Window index 3*row+col, row 0 = oldest line, col 0 = oldest column.
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= r_lb1[w_addr];
                r_win[3] <= r_win[4];
                r_win[4] <= r_win[5];
                r_win[5] <= r_lb0[w_addr];
                r_win[6] <= r_win[7];
                r_win[7] <= r_win[8];
                r_win[8] <= din;
            end
            if (w_adv) begin
                r_win_vld  <= w_acc && w_launch;
                r_sum_vld  <= r_win_vld;
                r_dout_vld <= r_sum_vld;
                if (r_win_vld) r_sum  <= w_mac;
                if (r_sum_vld) r_dout <= w_clamp;
            end
        end
    end

    always_comb begin
        w_mac = '0;
        for (int k = 0; k < 9; k++) begin
            w_prod[k] = r_coef[k] * $signed({1'b0, r_win[k]});
            w_mac     = w_mac + ACC_W'(w_prod[k]);
        end
    end

    always_comb begin
        w_shifted = r_sum >>> r_shift;
`ifdef DSP_CONV_ABS_EN
        w_mag = w_shifted[ACC_W-1] ? -w_shifted : w_shifted;
`else
        w_mag = w_shifted;
`endif
        if (w_mag[ACC_W-1])          w_clamp = '0;
        else if (w_mag > c_pix_max)  w_clamp = '1;
        else                         w_clamp = w_mag[PIX_W-1:0];
    end

    assign din_ready  = w_din_ready;
    assign cfg_err    = w_cfg_err;
    assign frame_done = w_frame_done;
    assign dout       = r_dout;
    assign dout_valid = r_dout_vld;

endmodule
`default_nettype wire

// File: tb/tb_dsp_conv3x3_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_conv3x3_stream
// Description : Directed self-checking bench for dsp_conv3x3_stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_conv3x3_stream;

    logic        dsp_clk = 1'b0;
    logic        reset;
    logic [10:0] cfg_width, cfg_height;
    logic [3:0]  cfg_shift;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [7:0]  coef_data;
    logic [7:0]  din;
    logic        din_valid, din_ready;
    logic [7:0]  dout;
    logic        dout_valid, dout_ready;
    logic        frame_done, cfg_err;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [7:0]  out_q [$];
    int          done_cnt = 0;
    int          pix   [64];
    int          exp_v [16];
    int          cf    [9];
    int          base_out, base_done;

    always #5 dsp_clk = ~dsp_clk;

    dsp_conv3x3_stream dut (
        .dsp_clk    (dsp_clk),
        .reset      (reset),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .cfg_shift  (cfg_shift),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .frame_done (frame_done),
        .cfg_err    (cfg_err)
    );

    // Handshakes seen at the negative edge complete on the following rising edge.
    always @(negedge dsp_clk) begin
        if (!reset && dout_valid && dout_ready) out_q.push_back(dout);
        if (frame_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic load_coefs();
        for (int k = 0; k < 9; k++) begin
            coef_we   = 1'b1;
            coef_addr = 4'(k);
            coef_data = 8'(cf[k]);
            @(posedge dsp_clk); #1;
        end
        coef_we = 1'b0;
    endtask

    task automatic send(input int n, input int stall_at, input int coef_at);
        logic       acc;
        logic [7:0] held;
        int         t;
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                din_valid  = 1'b0;
                dout_ready = 1'b0;
                repeat (3) begin @(posedge dsp_clk); #1; end
                din       = 8'(pix[i]);
                din_valid = 1'b1;
                @(negedge dsp_clk);
                chk("stall dout_valid", dout_valid, 1);
                held = dout;
                for (int s = 0; s < 10; s++) begin
                    @(negedge dsp_clk);
                    chk("stall dout", dout, held);
                    chk("stall dout_valid hold", dout_valid, 1);
                    chk("stall din_ready", din_ready, 0);
                end
                @(posedge dsp_clk); #1;
                dout_ready = 1'b1;
            end
            din       = 8'(pix[i]);
            din_valid = 1'b1;
            if (i == coef_at) begin
                coef_we   = 1'b1;
                coef_addr = 4'd4;
                coef_data = 8'd9;
            end
            acc = 1'b0;
            t   = 0;
            while (!acc && t < 100) begin
                @(negedge dsp_clk);
                acc = din_ready;
                @(posedge dsp_clk); #1;
                t++;
            end
            coef_we = 1'b0;
            chk("pixel accepted", acc, 1);
        end
        din_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int w, input int h, input int sh,
                             input int n_exp, input int stall_at, input int coef_at);
        int         t;
        logic [31:0] v;
        @(posedge dsp_clk); #1;
        cfg_width  = 11'(w);
        cfg_height = 11'(h);
        cfg_shift  = 4'(sh);
        base_out   = out_q.size();
        base_done  = done_cnt;
        send(w * h, stall_at, coef_at);
        t = 0;
        while (done_cnt == base_done && t < 300) begin
            @(negedge dsp_clk);
            t++;
        end
        repeat (4) @(negedge dsp_clk);
        chk({tag, " frame_done pulses"}, done_cnt - base_done, 1);
        chk({tag, " output count"}, out_q.size() - base_out, n_exp);
        for (int i = 0; i < n_exp; i++) begin
            v = (base_out + i < out_q.size()) ? 32'(out_q[base_out + i]) : 32'hDEAD;
            chk({tag, " value"}, v, exp_v[i]);
        end
    endtask

    initial begin
        reset = 1'b1; din = '0; din_valid = 1'b0; dout_ready = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        cfg_width = 11'd5; cfg_height = 11'd4; cfg_shift = 4'd3;
        repeat (3) begin @(posedge dsp_clk); #1; end
        chk("reset dout", dout, 0);
        chk("reset dout_valid", dout_valid, 0);
        chk("reset frame_done", frame_done, 0);
        chk("reset cfg_err", cfg_err, 0);
        chk("reset din_ready", din_ready, 0);
        reset = 1'b0;
        @(negedge dsp_clk);
        chk("idle din_ready", din_ready, 1);

        // Flat field, box filter: 90 >> 3 = 11
        cf = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        load_coefs();
        for (int i = 0; i < 20; i++) pix[i] = 10;
        for (int i = 0; i < 6; i++) exp_v[i] = 11;
        run_frame("flat", 5, 4, 3, 6, -1, -1);

        // Ramp has zero Laplacian
        cf = '{0, 1, 0, 1, -4, 1, 0, 1, 0};
        load_coefs();
        for (int i = 0; i < 12; i++) pix[i] = i;
        exp_v[0] = 0; exp_v[1] = 0;
        run_frame("laplace", 4, 3, 0, 2, -1, -1);

        // Upper saturation: 2295 -> 255
        cf = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        load_coefs();
        for (int i = 0; i < 9; i++) pix[i] = 255;
        exp_v[0] = 255;
        run_frame("sat hi", 3, 3, 0, 1, -1, -1);

        // Negative result: -255
        cf = '{0, 0, 0, 0, -1, 0, 0, 0, 0};
        load_coefs();
`ifdef DSP_CONV_ABS_EN
        exp_v[0] = 255;
`else
        exp_v[0] = 0;
`endif
        run_frame("sat neg", 3, 3, 0, 1, -1, -1);

        // Ramp through box filter with a 10-cycle output stall mid-frame
        cf = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        load_coefs();
        for (int i = 0; i < 20; i++) pix[i] = i;
        exp_v[0] = 6;  exp_v[1] = 7;  exp_v[2] = 9;
        exp_v[3] = 12; exp_v[4] = 13; exp_v[5] = 14;
        run_frame("stall", 5, 4, 3, 6, 14, -1);

        // Illegal width
        @(posedge dsp_clk); #1;
        cfg_width = 11'd2;
        base_out  = out_q.size();
        din = 8'd5; din_valid = 1'b1;
        @(negedge dsp_clk);
        chk("bad width cfg_err", cfg_err, 1);
        chk("bad width din_ready", din_ready, 0);
        repeat (6) @(negedge dsp_clk);
        chk("bad width no outputs", out_q.size() - base_out, 0);
        chk("bad width din_ready held", din_ready, 0);
        @(posedge dsp_clk); #1;
        din_valid = 1'b0;
        cfg_width = 11'd5;
        @(negedge dsp_clk);
        chk("good width cfg_err", cfg_err, 0);

        // Mid-frame write of e=9 applies only to the next frame: 170 >> 3 = 21
        for (int i = 0; i < 20; i++) pix[i] = 10;
        for (int i = 0; i < 6; i++) exp_v[i] = 11;
        run_frame("coef cur", 5, 4, 3, 6, -1, 3);
        for (int i = 0; i < 6; i++) exp_v[i] = 21;
        run_frame("coef next", 5, 4, 3, 6, -1, -1);

        // Abandon a frame with reset after 7 pixels
        @(posedge dsp_clk); #1;
        for (int i = 0; i < 20; i++) pix[i] = 200;
        base_done = done_cnt;
        send(7, -1, -1);
        reset = 1'b1;
        repeat (2) begin @(posedge dsp_clk); #1; end
        reset = 1'b0;
        repeat (3) @(negedge dsp_clk);
        chk("abort no frame_done", done_cnt - base_done, 0);
        chk("abort dout_valid", dout_valid, 0);
        cf = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        load_coefs();
        for (int i = 0; i < 20; i++) pix[i] = 10;
        for (int i = 0; i < 6; i++) exp_v[i] = 11;
        run_frame("after reset", 5, 4, 3, 6, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
